// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared state encoding, ASCII constants and character helpers for expr_gen
package expr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_OP    = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    localparam logic [7:0] CH_ZERO      = 8'h30;
    localparam logic [7:0] CH_PLUS      = 8'h2B;
    localparam logic [7:0] CH_STAR      = 8'h2A;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    // Nibbles 10..15 fold onto 4..9 so every LFSR value yields a decimal digit.
    function automatic logic [7:0] digit_char(input logic [7:0] v);
        logic [3:0] d;
        d = (v[3:0] > 4'd9) ? (v[3:0] - 4'd6) : v[3:0];
        return CH_ZERO + {4'h0, d};
    endfunction

    function automatic logic [7:0] op_char(input logic [7:0] v);
        return v[4] ? CH_STAR : CH_PLUS;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shift left with feedback into bit 0
module lfsr8
    import expr_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       step,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (step) begin
            q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            q_q <= DEFAULT_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/expr_gen.sv
// rtl/expr_gen.sv - pseudo-random arithmetic expression stream generator with optional malformed output
module expr_gen
    import expr_pkg::*;
#(
    parameter int unsigned MAX_OPS = 15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [3:0] len,
    input  logic [7:0] seed,
    input  logic       inject_err,
    output logic [7:0] out_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       expect_ok
);

    state_e     state_q, state_d;
    logic [3:0] len_q, len_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic       err_q, err_d;
    logic       dbl_q, dbl_d;
    logic       ok_q, ok_d;
    logic       start_ok;
    logic       accept;
    logic [7:0] lfsr_v;
    logic [7:0] seed_eff;

    assign start_ok = (state_q == ST_IDLE) && start;
    assign accept   = out_valid && out_ready;
    assign cnt_inc  = cnt_q + 4'd1;
    assign seed_eff = (seed == 8'h00) ? DEFAULT_SEED : seed;

    lfsr8 u_lfsr (
        .clk      (clk),
        .clr      (clr),
        .load     (start_ok),
        .load_val (seed_eff),
        .step     (accept),
        .q        (lfsr_v)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        dbl_d     = dbl_q;
        ok_d      = ok_q;
        out_valid = 1'b0;
        out_char  = 8'h00;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DIGIT;
                    cnt_d   = 4'd0;
                    dbl_d   = 1'b0;
                    err_d   = inject_err;
                    ok_d    = 1'b0;
                    if (len == 4'd0) begin
                        len_d = 4'd1;
                    end else if (32'(len) > MAX_OPS) begin
                        len_d = 4'(MAX_OPS);
                    end else begin
                        len_d = len;
                    end
                end
            end
            ST_DIGIT: begin
                out_valid = 1'b1;
                out_char  = digit_char(lfsr_v);
                if (out_ready) begin
                    cnt_d = cnt_inc;
                    // A single-digit malformed stream still needs its trailing operator.
                    if ((cnt_inc < len_q) || (err_q && (len_q == 4'd1))) begin
                        state_d = ST_OP;
                    end else begin
                        state_d = ST_FIN;
                        ok_d    = !err_q;
                    end
                end
            end
            ST_OP: begin
                out_valid = 1'b1;
                out_char  = op_char(lfsr_v);
                if (out_ready) begin
                    if (err_q && (len_q == 4'd1)) begin
                        state_d = ST_FIN;
                        ok_d    = 1'b0;
                    end else if (err_q && !dbl_q) begin
                        dbl_d = 1'b1;
                    end else begin
                        state_d = ST_DIGIT;
                    end
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            len_q   <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            dbl_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            dbl_q   <= dbl_d;
            ok_q    <= ok_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign expect_ok = ok_q;

endmodule

// File: tb/tb_expr_gen.sv
// tb/tb_expr_gen.sv - scoreboard testbench for expr_gen
module tb_expr_gen;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic [3:0] len = 4'd0;
    logic [7:0] seed = 8'h00;
    logic       inject_err = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_char;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic       expect_ok;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx[$];

    always #5 clk = ~clk;

    expr_gen #(.MAX_OPS(15)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .len        (len),
        .seed       (seed),
        .inject_err (inject_err),
        .out_char   (out_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .expect_ok  (expect_ok)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] m_step(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    function automatic logic [7:0] m_digit(input logic [7:0] v);
        int d;
        d = int'(v[3:0]);
        if (d > 9) d = d - 6;
        return 8'(8'h30 + d);
    endfunction

    function automatic logic [7:0] m_op(input logic [7:0] v);
        return v[4] ? 8'h2A : 8'h2B;
    endfunction

    function automatic bit is_op(input logic [7:0] c);
        return (c == 8'h2A) || (c == 8'h2B);
    endfunction

    // Reference recognizer: accepts exactly digit (op digit)*.
    function automatic bit recognize();
        if (rx.size() == 0 || (rx.size() % 2) == 0) return 1'b0;
        for (int i = 0; i < rx.size(); i++) begin
            if ((i % 2) == 0) begin
                if (rx[i] < 8'h30 || rx[i] > 8'h39) return 1'b0;
            end else if (!is_op(rx[i])) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic run_expr(input logic [7:0] sd, input logic [3:0] ln, input bit err, input int stall_at);
        logic [7:0] v;
        logic [7:0] hc;
        int n;
        int idx;
        int cyc;
        int want_len;
        bit fin;
        v = (sd == 8'h00) ? 8'hA5 : sd;
        n = (ln == 4'd0) ? 1 : int'(ln);
        exp_q.delete();
        rx.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(m_digit(v));
            v = m_step(v);
            if (i < n - 1 || (err && n == 1)) begin
                exp_q.push_back(m_op(v));
                v = m_step(v);
            end
            if (err && i == 0 && n >= 2) begin
                exp_q.push_back(m_op(v));
                v = m_step(v);
            end
        end
        want_len = exp_q.size();
        @(posedge clk); #1;
        start = 1'b1; seed = sd; len = ln; inject_err = err;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        idx = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (idx == stall_at && out_valid) begin
                hc = out_char;
                out_ready = 1'b0;
                start = 1'b1;
                seed = ~sd;
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_char", out_char, hc);
                    chk("hold_valid", out_valid, 1);
                end
                start = 1'b0;
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                rx.push_back(out_char);
                if (exp_q.size() == 0) chk("extra_char", rx.size(), want_len);
                else chk($sformatf("char%0d", idx), out_char, exp_q.pop_front());
                idx++;
            end else if (done) begin
                fin = 1'b1;
            end
        end
        chk("done_seen", fin, 1);
        chk("char_count", rx.size(), want_len);
        chk("expect_ok", expect_ok, !err);
        chk("recognizer", recognize(), !err);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after", busy, 0);
        chk("expect_ok_hold", expect_ok, !err);
    endtask

    initial begin
        int idx;
        int cyc;
        clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_char", out_char, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_expect_ok", expect_ok, 0);
        clr = 1'b1;

        run_expr(8'h07, 4'd1, 1'b0, -1);
        run_expr(8'h0C, 4'd0, 1'b0, -1);
        run_expr(8'h5B, 4'd3, 1'b0, -1);
        chk("len3_ops", {31'd0, is_op(rx[1]) && is_op(rx[3])}, 1);
        run_expr(8'h91, 4'd6, 1'b0, 2);
        run_expr(8'h4E, 4'd3, 1'b1, -1);
        chk("err_c2_op", is_op(rx[1]), 1);
        chk("err_c3_op", is_op(rx[2]), 1);
        run_expr(8'h13, 4'd1, 1'b1, -1);
        run_expr(8'h00, 4'd4, 1'b0, -1);
        run_expr(8'hC3, 4'd15, 1'b1, 7);

        // Reset during the third character aborts without a done pulse.
        @(posedge clk); #1;
        start = 1'b1; seed = 8'h3C; len = 4'd5; inject_err = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) idx++;
        end
        chk("abort_two_chars", idx, 2);
        @(negedge clk);
        chk("abort_third_valid", out_valid, 1);
        clr = 1'b0;
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        clr = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        run_expr(8'h22, 4'd2, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
